// File: rtl/axis_pkt_fifo.sv
// AXI4-Stream FIFO with optional store-and-forward packet mode.
// In packet mode a packet is only presented downstream once its tlast beat is stored,
// and a packet that cannot fit in the buffer is flushed and the rest of it discarded.
module axis_pkt_fifo #(
  parameter int unsigned DATA_WIDTH      = 8,
  parameter int unsigned DEPTH           = 16,
  parameter bit          PACKET_MODE     = 1'b1,
  parameter int unsigned ALMOST_FULL_LVL = DEPTH - 2
) (
  input  logic                     aclk,
  input  logic                     areset,
  input  logic                     s_axis_tvalid,
  output logic                     s_axis_tready,
  input  logic [DATA_WIDTH-1:0]    s_axis_tdata,
  input  logic                     s_axis_tlast,
  output logic                     m_axis_tvalid,
  input  logic                     m_axis_tready,
  output logic [DATA_WIDTH-1:0]    m_axis_tdata,
  output logic                     m_axis_tlast,
  output logic [$clog2(DEPTH):0]   occupancy,
  output logic [$clog2(DEPTH):0]   pkt_count,
  output logic                     almost_full,
  output logic                     drop_pulse
);

  localparam int unsigned AW = $clog2(DEPTH);
  localparam int unsigned CW = AW + 1;

  typedef enum logic [0:0] {StPass, StDrop} state_e;

  state_e              state_q;
  logic                drop_q;
  logic [DATA_WIDTH:0] mem_q [DEPTH];
  logic [AW-1:0]       wr_ptr_q, wr_ptr_d;
  logic [AW-1:0]       rd_ptr_q, rd_ptr_d;
  logic [CW-1:0]       occ_q, occ_d;
  logic [CW-1:0]       pkt_q, pkt_d;

  logic wr_acc;   // handshake on the slave side, including beats discarded in DROP
  logic wr_en;    // beat actually stored
  logic rd_en;
  logic flush;

  assign s_axis_tready = !areset && (state_q == StDrop || occ_q < CW'(DEPTH));
  assign wr_acc        = s_axis_tvalid && s_axis_tready;
  assign wr_en         = wr_acc && (state_q == StPass);

  // Packet mode only presents data once at least one whole packet is stored.
  assign m_axis_tvalid = PACKET_MODE ? (pkt_q != '0 && state_q == StPass) : (occ_q != '0);
  assign rd_en         = m_axis_tvalid && m_axis_tready;
  assign m_axis_tdata  = mem_q[rd_ptr_q][DATA_WIDTH-1:0];
  assign m_axis_tlast  = mem_q[rd_ptr_q][DATA_WIDTH];

  // Buffer full with no complete packet: the packet can never be released, so flush it.
  assign flush = PACKET_MODE && (state_q == StPass) && (occ_q == CW'(DEPTH)) && (pkt_q == '0);

  assign occupancy   = occ_q;
  assign pkt_count   = pkt_q;
  assign almost_full = !areset && (32'(occ_q) >= ALMOST_FULL_LVL);
  assign drop_pulse  = drop_q;

  // Next-state for pointers, occupancy and packet count.
  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    occ_d    = occ_q;
    pkt_d    = pkt_q;
    if (rd_en) rd_ptr_d = rd_ptr_q + AW'(1);
    if (flush) begin
      wr_ptr_d = rd_ptr_q;
      occ_d    = '0;
    end else begin
      if (wr_en) wr_ptr_d = wr_ptr_q + AW'(1);
      if (wr_en && !rd_en) occ_d = occ_q + CW'(1);
      else if (!wr_en && rd_en) occ_d = occ_q - CW'(1);
    end
    if (PACKET_MODE) begin
      if ((wr_en && s_axis_tlast) && !(rd_en && m_axis_tlast)) pkt_d = pkt_q + CW'(1);
      else if (!(wr_en && s_axis_tlast) && (rd_en && m_axis_tlast)) pkt_d = pkt_q - CW'(1);
    end else begin
      pkt_d = '0;
    end
  end

  // Storage array; contents need no reset since pointers define validity.
  always_ff @(posedge aclk) begin
    if (wr_en) mem_q[wr_ptr_q] <= {s_axis_tlast, s_axis_tdata};
  end

  // Pointer, occupancy and packet-count registers.
  always_ff @(posedge aclk or posedge areset) begin
    if (areset) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      occ_q    <= '0;
      pkt_q    <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      occ_q    <= occ_d;
      pkt_q    <= pkt_d;
    end
  end

  // PASS/DROP state machine with registered one-cycle drop pulse.
  always_ff @(posedge aclk or posedge areset) begin
    if (areset) begin
      state_q <= StPass;
      drop_q  <= 1'b0;
    end else begin
      drop_q <= 1'b0;
      case (state_q)
        StPass: begin
          if (flush) begin
            state_q <= StDrop;
            drop_q  <= 1'b1;
          end
        end
        StDrop: begin
          if (wr_acc && s_axis_tlast) state_q <= StPass;
        end
        default: state_q <= StPass;
      endcase
    end
  end

endmodule

// File: tb/tb_axis_pkt_fifo.sv
// Bench for axis_pkt_fifo: instance 0 is cut-through, instance 1 is packet mode (DEPTH=8).
module tb_axis_pkt_fifo;

  localparam int unsigned DW    = 8;
  localparam int unsigned DEPTH = 8;
  localparam int unsigned CW    = 4;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          s_valid [2];
  logic          s_ready [2];
  logic [DW-1:0] s_data  [2];
  logic          s_last  [2];
  logic          m_valid [2];
  logic          m_ready [2];
  logic [DW-1:0] m_data  [2];
  logic          m_last  [2];
  logic [CW-1:0] occ     [2];
  logic [CW-1:0] pkt     [2];
  logic          af      [2];
  logic          drop    [2];

  logic [8:0] q0[$];
  logic [8:0] q1[$];
  int total = 0;
  int bad   = 0;
  int ndrop = 0;
  int pk_max = 0;
  bit done;

  always #5 clk = ~clk;

  axis_pkt_fifo #(
    .DATA_WIDTH(DW), .DEPTH(DEPTH), .PACKET_MODE(1'b0), .ALMOST_FULL_LVL(6)
  ) u_fifo_s (
    .aclk(clk), .areset(rst),
    .s_axis_tvalid(s_valid[0]), .s_axis_tready(s_ready[0]),
    .s_axis_tdata(s_data[0]), .s_axis_tlast(s_last[0]),
    .m_axis_tvalid(m_valid[0]), .m_axis_tready(m_ready[0]),
    .m_axis_tdata(m_data[0]), .m_axis_tlast(m_last[0]),
    .occupancy(occ[0]), .pkt_count(pkt[0]), .almost_full(af[0]), .drop_pulse(drop[0])
  );

  axis_pkt_fifo #(
    .DATA_WIDTH(DW), .DEPTH(DEPTH), .PACKET_MODE(1'b1), .ALMOST_FULL_LVL(6)
  ) u_fifo_p (
    .aclk(clk), .areset(rst),
    .s_axis_tvalid(s_valid[1]), .s_axis_tready(s_ready[1]),
    .s_axis_tdata(s_data[1]), .s_axis_tlast(s_last[1]),
    .m_axis_tvalid(m_valid[1]), .m_axis_tready(m_ready[1]),
    .m_axis_tdata(m_data[1]), .m_axis_tlast(m_last[1]),
    .occupancy(occ[1]), .pkt_count(pkt[1]), .almost_full(af[1]), .drop_pulse(drop[1])
  );

  task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got=%0h want=%0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Present one beat and hold it until accepted; returns 1 time unit after the accepting edge.
  task automatic send(input int i, input logic [7:0] d, input logic l);
    int n = 0;
    s_valid[i] = 1'b1;
    s_data[i]  = d;
    s_last[i]  = l;
    @(negedge clk);
    while (!s_ready[i] && n < 200) begin
      @(negedge clk);
      n++;
    end
    check_val("send_ready", 32'(s_ready[i]), 1);
    @(posedge clk);
    #1;
    s_valid[i] = 1'b0;
    s_last[i]  = 1'b0;
  endtask

  task automatic wait_empty(input int i);
    int n = 0;
    while (((i == 0) ? q0.size() : q1.size()) != 0 && n < 300) begin
      tick();
      n++;
    end
    check_val("drain", (i == 0) ? q0.size() : q1.size(), 0);
  endtask

  task automatic check_rst(input int i);
    check_val("rst_s_ready", 32'(s_ready[i]), 0);
    check_val("rst_m_valid", 32'(m_valid[i]), 0);
    check_val("rst_occ", 32'(occ[i]), 0);
    check_val("rst_pkt", 32'(pkt[i]), 0);
    check_val("rst_af", 32'(af[i]), 0);
    check_val("rst_drop", 32'(drop[i]), 0);
  endtask

  // Output scoreboard: a handshake seen mid-cycle completes at the next rising edge.
  always @(negedge clk) begin
    if (!rst) begin
      if (m_valid[0] && m_ready[0]) begin
        if (q0.size() == 0) check_val("m0_unexpected_beat", q0.size(), 1);
        else check_val("m0_beat", {23'd0, m_last[0], m_data[0]}, {23'd0, q0.pop_front()});
      end
      if (m_valid[1] && m_ready[1]) begin
        if (q1.size() == 0) check_val("m1_unexpected_beat", q1.size(), 1);
        else check_val("m1_beat", {23'd0, m_last[1], m_data[1]}, {23'd0, q1.pop_front()});
      end
      if (drop[1]) ndrop++;
      if (int'(pkt[1]) > pk_max) pk_max = int'(pkt[1]);
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got=timeout want=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    for (int i = 0; i < 2; i++) begin
      s_valid[i] = 1'b0;
      s_data[i]  = '0;
      s_last[i]  = 1'b0;
      m_ready[i] = 1'b0;
    end
    #2;
    check_rst(0);
    check_rst(1);
    #20 rst = 1'b0;
    tick();

    // Cut-through: fill to full with downstream stalled.
    for (int k = 1; k <= 8; k++) begin
      q0.push_back({1'b0, 8'(k)});
      send(0, 8'(k), 1'b0);
      if (k == 5) check_val("af_at5", 32'(af[0]), 0);
      if (k == 6) check_val("af_at6", 32'(af[0]), 1);
    end
    check_val("full_occ", 32'(occ[0]), 8);
    check_val("full_ready", 32'(s_ready[0]), 0);
    // Read and write requested together at full: write must be refused.
    q0.push_back({1'b0, 8'h09});
    s_valid[0] = 1'b1;
    s_data[0]  = 8'h09;
    m_ready[0] = 1'b1;
    check_val("full_rw_ready", 32'(s_ready[0]), 0);
    tick();
    check_val("full_rw_occ", 32'(occ[0]), 7);
    check_val("after_full_ready", 32'(s_ready[0]), 1);
    tick();
    check_val("rw7_occ", 32'(occ[0]), 7);
    s_valid[0] = 1'b0;
    q0.push_back({1'b0, 8'h0A});
    send(0, 8'h0A, 1'b0);
    wait_empty(0);
    check_val("drained_occ", 32'(occ[0]), 0);

    // Simultaneous read+write at occupancy 1.
    q0.push_back({1'b0, 8'h40});
    send(0, 8'h40, 1'b0);
    check_val("occ1_a", 32'(occ[0]), 1);
    q0.push_back({1'b0, 8'h41});
    send(0, 8'h41, 1'b0);
    check_val("occ1_b", 32'(occ[0]), 1);
    wait_empty(0);

    // Pointer wrap over 3x DEPTH beats with random downstream stalls.
    done = 1'b0;
    fork
      begin
        for (int k = 0; k < 24; k++) begin
          q0.push_back({1'b0, 8'(8'h80 + k)});
          send(0, 8'(8'h80 + k), 1'b0);
        end
        done = 1'b1;
      end
      begin
        while (!done) begin
          m_ready[0] = 1'($urandom_range(0, 1));
          tick();
        end
      end
    join
    m_ready[0] = 1'b1;
    wait_empty(0);

    // Packet mode: nothing released before tlast is stored.
    m_ready[1] = 1'b0;
    q1.push_back({1'b0, 8'hA0});
    q1.push_back({1'b0, 8'hA1});
    q1.push_back({1'b1, 8'hA2});
    send(1, 8'hA0, 1'b0);
    check_val("pkt_hold0", 32'(m_valid[1]), 0);
    tick();
    send(1, 8'hA1, 1'b0);
    check_val("pkt_hold1", 32'(m_valid[1]), 0);
    tick();
    send(1, 8'hA2, 1'b1);
    check_val("pkt_rel_valid", 32'(m_valid[1]), 1);
    check_val("pkt_rel_count", 32'(pkt[1]), 1);
    check_val("pkt_rel_head", 32'(m_data[1]), 32'h0A0);
    m_ready[1] = 1'b1;
    wait_empty(1);
    check_val("pkt_count_done", 32'(pkt[1]), 0);
    check_val("pkt_valid_done", 32'(m_valid[1]), 0);

    // Back-to-back packets with downstream ready toggling every cycle.
    pk_max = 0;
    q1.push_back({1'b0, 8'hB0});
    q1.push_back({1'b1, 8'hB1});
    q1.push_back({1'b0, 8'hC0});
    q1.push_back({1'b0, 8'hC1});
    q1.push_back({1'b1, 8'hC2});
    done = 1'b0;
    fork
      begin
        send(1, 8'hB0, 1'b0);
        send(1, 8'hB1, 1'b1);
        send(1, 8'hC0, 1'b0);
        send(1, 8'hC1, 1'b0);
        send(1, 8'hC2, 1'b1);
        done = 1'b1;
      end
      begin
        for (int k = 0; k < 40 && (!done || q1.size() != 0); k++) begin
          m_ready[1] = k[0];
          tick();
        end
      end
    join
    m_ready[1] = 1'b1;
    wait_empty(1);
    check_val("pkt_peak", pk_max, 2);

    // Oversize packet is flushed and its tail dropped; the next packet survives.
    ndrop = 0;
    for (int k = 0; k < 12; k++) begin
      send(1, 8'(8'h10 + k), k == 11);
      if (k == 7) begin
        check_val("ovf_occ", 32'(occ[1]), 8);
        check_val("ovf_ready", 32'(s_ready[1]), 0);
      end
      if (k == 8) check_val("drop_occ", 32'(occ[1]), 0);
    end
    check_val("drop_pulses", ndrop, 1);
    q1.push_back({1'b0, 8'h30});
    q1.push_back({1'b1, 8'h31});
    send(1, 8'h30, 1'b0);
    send(1, 8'h31, 1'b1);
    wait_empty(1);
    check_val("post_drop_occ", 32'(occ[1]), 0);

    // Asynchronous reset mid-cycle with data in cut-through and packet FIFO in DROP.
    m_ready[0] = 1'b0;
    for (int k = 0; k < 5; k++) send(0, 8'(8'h70 + k), 1'b0);
    check_val("pre_rst_occ", 32'(occ[0]), 5);
    for (int k = 0; k < 9; k++) send(1, 8'(8'h60 + k), 1'b0);
    check_val("pre_rst_drop_ready", 32'(s_ready[1]), 1);
    check_val("pre_rst_drop_occ", 32'(occ[1]), 0);
    @(negedge clk);
    #2 rst = 1'b1;
    #1;
    check_rst(0);
    check_rst(1);
    #1 rst = 1'b0;
    tick();
    check_val("post_rst_valid0", 32'(m_valid[0]), 0);
    m_ready[1] = 1'b1;
    q1.push_back({1'b1, 8'h55});
    send(1, 8'h55, 1'b1);
    wait_empty(1);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
